// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and
// the fetch FSM state encoding.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect load and sequential increment.
// Optional build macro FETCH_WRAP_HALT_EN: the PC holds at its last address
// instead of wrapping, and wrap_stop_o flags that the last address is live.
module fetch_pc_reg #(
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              wrap_stop_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect wins over increment; otherwise hold.
  always_comb begin
    pc_d        = pc_q;
`ifdef FETCH_WRAP_HALT_EN
    wrap_stop_o = (pc_q == {ADDR_W{1'b1}});
    if (load_i) begin
      pc_d = redirect_pc_i;
    end else if (inc_i && !wrap_stop_o) begin
      pc_d = pc_q + ADDR_W'(1);
    end
`else
    wrap_stop_o = 1'b0;
    if (load_i) begin
      pc_d = redirect_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
`endif
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the ROM address from the PC and registers
// the returned instruction into a valid/ready output slot toward decode.
// Supports back-pressure stalls, redirects with slot flush, and halt.
// Optional build macro FETCH_WRAP_HALT_EN: halt after fetching the last
// ROM address instead of wrapping to 0.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               halt_pend_q, halt_pend_d;
  logic               pc_load;
  logic               pc_inc;
  logic               wrap_stop;
  logic               adv;
  logic [ADDR_W-1:0]  pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (pc_load),
    .redirect_pc_i (redirect_pc),
    .inc_i         (pc_inc),
    .pc_o          (pc),
    .wrap_stop_o   (wrap_stop)
  );

  assign adv = !out_valid_q || out_ready;

  // Fetch FSM and slot next-state. A halt request (or the wrap stop) is
  // remembered in halt_pend so a single-cycle request still drains the slot.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    halt_pend_d = halt_pend_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_RUN;
      end
      FS_RUN: begin
        if (redirect_valid) begin
          pc_load     = 1'b1;
          out_valid_d = 1'b0;
          halt_pend_d = 1'b0;
          if (halt_req) begin
            state_d = FS_HALT;
          end
        end else if (halt_req || halt_pend_q) begin
          halt_pend_d = 1'b1;
          if (adv) begin
            out_valid_d = 1'b0;
            state_d     = FS_HALT;
          end
        end else if (adv) begin
          out_valid_d = 1'b1;
          out_instr_d = imem_instr;
          out_pc_d    = pc;
          pc_inc      = 1'b1;
          if (wrap_stop) begin
            halt_pend_d = 1'b1;
          end
        end
      end
      FS_HALT: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
        end
      end
      default: begin
        state_d = FS_BOOT;
      end
    endcase
  end

  // State and output slot registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_BOOT;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign imem_addr = pc;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == FS_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a ROM returning 2*addr.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [3:0]  out_pc;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        halt_req;
  logic        halted;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign imem_instr = 16'(2 * int'(imem_addr));

  instr_fetch_unit #(
    .ADDR_W   (4),
    .INSTR_W  (16),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    halt_req       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset, then free-run until the slot holds address p.
  task automatic reset_and_run_to(input int p);
    do_reset();
    tick();
    repeat (p + 1) tick();
  endtask

  task automatic test_reset;
    logic [24:0] got, exp;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 4'd0; halt_req = 1'b0;
    #1;
    got = {out_valid, halted, imem_addr, out_pc, out_instr[14:0]};
    exp = '0;
    total++;
    if (got !== exp) $display("FAIL reset_state: got %h expected %h", got, exp);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL boot_no_capture: got %b expected 0", out_valid);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = {out_valid, out_pc, out_instr, imem_addr};
      exp = {1'b1, 4'(i), 16'(2 * i), 4'(i + 1)};
      total++;
      if (got !== exp) $display("FAIL stream_%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_stall;
    logic [24:0] got, exp;
    reset_and_run_to(4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {out_valid, out_pc, out_instr, imem_addr};
      exp = {1'b1, 4'd4, 16'd8, 4'd5};
      total++;
      if (got !== exp) $display("FAIL stall_hold_%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
    out_ready = 1'b1;
    for (int i = 5; i < 7; i++) begin
      tick();
      got = {out_valid, out_pc, out_instr, imem_addr};
      exp = {1'b1, 4'(i), 16'(2 * i), 4'(i + 1)};
      total++;
      if (got !== exp) $display("FAIL stall_release_%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_redirect;
    logic [24:0] got, exp;
    reset_and_run_to(3);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd12;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({out_valid, imem_addr} !== {1'b0, 4'd12})
      $display("FAIL redirect_flush: got %b/%0d expected 0/12", out_valid, imem_addr);
    else passed++;
    for (int i = 12; i < 14; i++) begin
      tick();
      got = {out_valid, out_pc, out_instr, imem_addr};
      exp = {1'b1, 4'(i), 16'(2 * i), 4'(i + 1)};
      total++;
      if (got !== exp) $display("FAIL redirect_target_%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  // Continues from the redirect scenario (slot at 13, ready high).
  task automatic test_wrap;
    tick();
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 4'd15, 16'd30})
      $display("FAIL wrap_last: got %b/%0d/%0d expected 1/15/30", out_valid, out_pc, out_instr);
    else passed++;
`ifdef FETCH_WRAP_HALT_EN
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({out_valid, halted} !== 2'b01)
        $display("FAIL wrap_halt_%0d: got valid=%b halted=%b expected valid=0 halted=1", i, out_valid, halted);
      else passed++;
    end
`else
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({out_valid, halted, out_pc, out_instr} !== {2'b10, 4'(i), 16'(2 * i)})
        $display("FAIL wrap_around_%0d: got %b/%b/%0d/%0d expected 1/0/%0d/%0d",
                 i, out_valid, halted, out_pc, out_instr, i, 2 * i);
      else passed++;
    end
`endif
  endtask

  task automatic test_halt;
    reset_and_run_to(7);
    out_ready = 1'b0;
    halt_req  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      halt_req = 1'b0;
      total++;
      if ({out_valid, halted, out_pc, out_instr} !== {2'b10, 4'd7, 16'd14})
        $display("FAIL halt_hold_%0d: got %b/%b/%0d/%0d expected 1/0/7/14",
                 i, out_valid, halted, out_pc, out_instr);
      else passed++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      halt_req = 1'b1;
      total++;
      if ({out_valid, halted, imem_addr} !== {2'b01, 4'd8})
        $display("FAIL halt_frozen_%0d: got %b/%b/%0d expected 0/1/8", i, out_valid, halted, imem_addr);
      else passed++;
    end
    halt_req       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 4'd3;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, halted, imem_addr} !== {2'b01, 4'd3})
      $display("FAIL halt_redirect: got %b/%b/%0d expected 0/1/3", out_valid, halted, imem_addr);
    else passed++;
  endtask

  task automatic test_redirect_halt;
    reset_and_run_to(2);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd5;
    halt_req       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({out_valid, halted, imem_addr} !== {2'b01, 4'd5})
        $display("FAIL redirect_halt_%0d: got %b/%b/%0d expected 0/1/5", i, out_valid, halted, imem_addr);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_stall;
    reset_and_run_to(9);
    out_ready = 1'b0;
    tick();
    tick();
    total++;
    if ({out_valid, out_pc} !== {1'b1, 4'd9})
      $display("FAIL pre_reset_stall: got %b/%0d expected 1/9", out_valid, out_pc);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, imem_addr, halted, out_pc} !== 10'd0)
      $display("FAIL async_reset: got %b/%0d/%b/%0d expected 0/0/0/0", out_valid, imem_addr, halted, out_pc);
    else passed++;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
  endtask

  // Random ready/redirect traffic. The reference is transaction-level: each
  // newly presented slot must carry the successor of the previously
  // presented address (or the redirect target), with instr = 2*pc; a stalled
  // slot must not change; a redirect must leave the slot empty.
  task automatic test_random;
    logic [3:0]  exp_next;
    logic        r_ready, r_red, sv;
    logic [3:0]  r_rpc, sp;
    logic [15:0] si;
    logic [25:0] got, exp;
    reset_and_run_to(0);
    exp_next = 4'd1;
    for (int n = 0; n < 400; n++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = 4'($urandom_range(0, 15));
`ifdef FETCH_WRAP_HALT_EN
      if (imem_addr >= 4'd12) begin
        redirect_valid = 1'b1;
        redirect_pc    = 4'($urandom_range(0, 11));
      end
`endif
      r_ready = out_ready; r_red = redirect_valid; r_rpc = redirect_pc;
      sv = out_valid; sp = out_pc; si = out_instr;
      tick();
      total++;
      if (r_red) begin
        if ({out_valid, halted, imem_addr} !== {2'b00, r_rpc}) begin
          $display("FAIL rand_redirect_%0d: got %b/%b/%0d expected 0/0/%0d", n, out_valid, halted, imem_addr, r_rpc);
        end else passed++;
        exp_next = r_rpc;
      end else if (sv && !r_ready) begin
        got = {out_valid, halted, out_pc, out_instr, imem_addr};
        exp = {2'b10, sp, si, imem_addr};
        if (got[25:4] !== exp[25:4])
          $display("FAIL rand_stall_%0d: got %h expected %h", n, got, exp);
        else passed++;
      end else begin
        got = {out_valid, halted, out_pc, out_instr, imem_addr};
        exp = {2'b10, exp_next, 16'(2 * int'(exp_next)), exp_next + 4'd1};
        if (got !== exp)
          $display("FAIL rand_advance_%0d: got %h expected %h", n, got, exp);
        else passed++;
        exp_next = exp_next + 4'd1;
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_redirect_halt();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
